wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback stage directly upstream of the 64-bit, 32-entry integer register file; its single write port is driven only by this block.
- Accepts completed instructions from execute on a valid/ready handshake and handles load returns from data memory, including byte-lane extraction and sign/zero extension.
- Produces one registered write per retired instruction and maintains the retired-instruction counter.

Parameters:
- LOAD_TIMEOUT, 0, cycles allowed in LOAD_WAIT before the load is abandoned; 0 disables the timeout.
- INSTRET_W, 64, width of the instret counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- ex_valid  input  1  execute holds a completed instruction.
- ex_ready  output  1  stage can accept; combinational, equals (state != LOAD_WAIT).
- ex_rd  input  5  destination register.
- ex_result  input  64  ALU result, or effective address for loads.
- ex_is_load  input  1  instruction is a load.
- ex_funct3  input  3  load size/sign code.
- ex_pc  input  64  instruction PC.
- ex_instr  input  32  instruction word.
- mem_req  output  1  load read request; combinational, ex_valid & ex_ready & ex_is_load.
- mem_addr  output  64  equals ex_result.
- mem_rvalid  input  1  load data returned.
- mem_rdata  input  64  aligned 8-byte doubleword containing the load.
- wr_en  output  1  register-file write enable.
- wr_addr  output  5  register-file write address.
- wr_data  output  64  register-file write data.
- load_err  output  1  one-cycle pulse when a load is abandoned on timeout.
- instret  output  INSTRET_W  retired-instruction count.
- commit_valid  output  1  retire pulse (see Optional Feature).
- commit_pc  output  64  PC of the retiring instruction.
- commit_instr  output  32  instruction word of the retiring instruction.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - wr_en, wr_addr, wr_data, load_err, instret and all commit_* outputs = 0.
  - A load pending in LOAD_WAIT is discarded; a mem_rvalid arriving after reset release with no load pending is ignored.
- States: IDLE, LOAD_WAIT.
- IDLE, non-load accept (ex_valid & ~ex_is_load):
  - Next cycle: wr_en=(ex_rd!=0), wr_addr=ex_rd, wr_data=ex_result; one retire.
  - Back-to-back accepts are allowed every cycle, giving 1-cycle latency and full throughput.
- IDLE, load accept:
  - mem_req=1 in the accept cycle.
  - Latch rd, funct3, addr[2:0], pc and instr; go to LOAD_WAIT.
- LOAD_WAIT:
  - ex_ready=0.
  - On mem_rvalid: next cycle wr_en=(rd!=0) with the extracted data, one retire, state returns to IDLE.
  - The stage re-accepts from execute in that same write cycle.
- Load extraction:
  - sh = mem_rdata >> (addr[2:0]*8), zero-filled from the top.
  - funct3 000 LB: sign-extend sh[7:0].
  - 001 LH: sign-extend sh[15:0].
  - 010 LW: sign-extend sh[31:0].
  - 011 LD: sh unchanged.
  - 100 LBU: zero-extend sh[7:0].
  - 101 LHU: zero-extend sh[15:0].
  - 110 LWU: zero-extend sh[31:0].
  - 111: treated as LD.
  - A misaligned access that crosses the doubleword boundary uses zero-filled upper bytes; no trap is raised.
- Timeout (LOAD_TIMEOUT>0):
  - Counter is cleared on entry to LOAD_WAIT.
  - When the count reaches LOAD_TIMEOUT with no mem_rvalid: pulse load_err for one cycle, no write, no retire, go to IDLE.
  - mem_rvalid in the same cycle as expiry wins; the load completes normally.
- Writes to x0:
  - rd=0 never asserts wr_en.
  - The instruction still retires: instret increments and commit_valid fires.
- wr_en is a one-cycle pulse per retire; wr_addr and wr_data hold their last values while wr_en=0.
- instret wraps modulo 2^INSTRET_W.

Optional Feature:
- Macro: WB_COMMIT_TRACE_EN.
- Defined: commit_valid pulses in the retire cycle, aligned with wr_en timing. commit_pc and commit_instr carry the retiring instruction's values, from the latch for loads.
- Undefined: commit_valid, commit_pc and commit_instr are tied to 0. The pc/instr latches are removed, and ex_pc/ex_instr are ignored.

Test Plan:
- Non-load, x5: ex_valid, ex_rd=5, ex_result=0x1234 -> next cycle wr_en=1, wr_addr=5, wr_data=0x1234; instret=1.
- Load LB, addr 0x...3: mem_rdata=0x0000_0000_8000_0000 (byte 3 = 0x80), mem_rvalid two cycles later -> ex_ready=0 while waiting; wr_data=0xFFFF_FFFF_FFFF_FF80; LBU on the same data -> 0x80.
- Back-to-back ALU, three consecutive cycles to x1, x2, x0 -> writes to x1 and x2 on consecutive cycles; third cycle wr_en=0; instret=3.
- LOAD_TIMEOUT=4, no mem_rvalid -> load_err pulses 4 cycles after entry; no write; ex_ready=1 on the next cycle; instret unchanged.
- Reset asserted mid-LOAD_WAIT, then mem_rvalid after release -> no write, all outputs 0, state IDLE.
- With WB_COMMIT_TRACE_EN, ex_pc=0x8000_0000, ex_instr=0x0000_0013 -> commit_valid=1 with matching pc and instr in the wr_en cycle.

Source files
------------

// File: rtl/wb_stage_if.sv
// Writeback-stage bus: execute handshake, data-memory load port, register-file
// write port, retire counter and commit trace.
interface wb_stage_if #(
   parameter int INSTRET_W = 64
);
   logic                 ex_valid;
   logic                 ex_ready;
   logic [4:0]           ex_rd;
   logic [63:0]          ex_result;
   logic                 ex_is_load;
   logic [2:0]           ex_funct3;
   logic [63:0]          ex_pc;
   logic [31:0]          ex_instr;
   logic                 mem_req;
   logic [63:0]          mem_addr;
   logic                 mem_rvalid;
   logic [63:0]          mem_rdata;
   logic                 wr_en;
   logic [4:0]           wr_addr;
   logic [63:0]          wr_data;
   logic                 load_err;
   logic [INSTRET_W-1:0] instret;
   logic                 commit_valid;
   logic [63:0]          commit_pc;
   logic [31:0]          commit_instr;

   // The writeback stage is the slave; execute, memory and consumers form the master side.
   modport slave (
      input  ex_valid, ex_rd, ex_result, ex_is_load, ex_funct3, ex_pc, ex_instr,
             mem_rvalid, mem_rdata,
      output ex_ready, mem_req, mem_addr, wr_en, wr_addr, wr_data, load_err,
             instret, commit_valid, commit_pc, commit_instr
   );

   modport master (
      output ex_valid, ex_rd, ex_result, ex_is_load, ex_funct3, ex_pc, ex_instr,
             mem_rvalid, mem_rdata,
      input  ex_ready, mem_req, mem_addr, wr_en, wr_addr, wr_data, load_err,
             instret, commit_valid, commit_pc, commit_instr
   );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: retires ALU results and load returns into the register file.
// Optional commit trace enabled by defining WB_COMMIT_TRACE_EN.
module wb_stage #(
   parameter int LOAD_TIMEOUT = 0,
   parameter int INSTRET_W    = 64
) (
   input logic       clk,
   input logic       rst,
   wb_stage_if.slave bus
);
   typedef enum logic {S_IDLE, S_LOAD_WAIT} state_e;

   localparam int CNT_W = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOAD_TIMEOUT - 1);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     tmo_cnt_q, tmo_cnt_d;
   logic [4:0]           ld_rd_q;
   logic [2:0]           ld_funct3_q;
   logic [2:0]           ld_off_q;
   logic                 wr_en_q, wr_en_d;
   logic [4:0]           wr_addr_q, wr_addr_d;
   logic [63:0]          wr_data_q, wr_data_d;
   logic                 load_err_q, load_err_d;
   logic [INSTRET_W-1:0] instret_q, instret_d;
   logic                 retire;
   logic [4:0]           ret_rd;
   logic [63:0]          ret_val;
   logic                 expire;

   function automatic logic [63:0] extract(input logic [63:0] rdata,
                                           input logic [2:0]  off,
                                           input logic [2:0]  funct3);
      logic [63:0] sh;
      logic [63:0] res;
      sh = rdata >> {off, 3'b000};
      case (funct3)
         3'b000:  res = {{56{sh[7]}},  sh[7:0]};
         3'b001:  res = {{48{sh[15]}}, sh[15:0]};
         3'b010:  res = {{32{sh[31]}}, sh[31:0]};
         3'b100:  res = {56'd0, sh[7:0]};
         3'b101:  res = {48'd0, sh[15:0]};
         3'b110:  res = {32'd0, sh[31:0]};
         default: res = sh;
      endcase
      return res;
   endfunction

   assign bus.ex_ready = (state_q != S_LOAD_WAIT);
   assign bus.mem_req  = bus.ex_valid & bus.ex_ready & bus.ex_is_load;
   assign bus.mem_addr = bus.ex_result;
   assign expire       = (LOAD_TIMEOUT != 0) && (tmo_cnt_q == TMO_LAST);

   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch is inferred.
      state_d    = state_q;
      tmo_cnt_d  = tmo_cnt_q;
      load_err_d = 1'b0;
      retire     = 1'b0;
      ret_rd     = 5'd0;
      ret_val    = 64'd0;
      case (state_q)
         S_IDLE: begin
            if (bus.ex_valid) begin
               if (bus.ex_is_load) begin
                  state_d   = S_LOAD_WAIT;
                  tmo_cnt_d = '0;
               end else begin
                  retire  = 1'b1;
                  ret_rd  = bus.ex_rd;
                  ret_val = bus.ex_result;
               end
            end
         end
         S_LOAD_WAIT: begin
            // A return in the expiry cycle still completes the load.
            if (bus.mem_rvalid) begin
               retire  = 1'b1;
               ret_rd  = ld_rd_q;
               ret_val = extract(bus.mem_rdata, ld_off_q, ld_funct3_q);
               state_d = S_IDLE;
            end else if (expire) begin
               load_err_d = 1'b1;
               state_d    = S_IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // x0 retires without touching the write port; address/data hold otherwise.
      wr_en_d   = retire && (ret_rd != 5'd0);
      wr_addr_d = wr_en_d ? ret_rd  : wr_addr_q;
      wr_data_d = wr_en_d ? ret_val : wr_data_q;
      instret_d = instret_q + INSTRET_W'(retire);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         tmo_cnt_q  <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= 5'd0;
         wr_data_q  <= 64'd0;
         load_err_q <= 1'b0;
         instret_q  <= '0;
      end else begin
         state_q    <= state_d;
         tmo_cnt_q  <= tmo_cnt_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         load_err_q <= load_err_d;
         instret_q  <= instret_d;
      end
   end

   // NOTE: load-capture registers are not reset; they are only read in LOAD_WAIT, reachable only after a capture.
   always_ff @(posedge clk) begin
      if (bus.mem_req) begin
         ld_rd_q     <= bus.ex_rd;
         ld_funct3_q <= bus.ex_funct3;
         ld_off_q    <= bus.ex_result[2:0];
      end
   end

   assign bus.wr_en    = wr_en_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_data  = wr_data_q;
   assign bus.load_err = load_err_q;
   assign bus.instret  = instret_q;

`ifdef WB_COMMIT_TRACE_EN
   logic [63:0] ld_pc_q;
   logic [31:0] ld_instr_q;
   logic        commit_valid_q;
   logic [63:0] commit_pc_q;
   logic [31:0] commit_instr_q;

   always_ff @(posedge clk) begin
      if (bus.mem_req) begin
         ld_pc_q    <= bus.ex_pc;
         ld_instr_q <= bus.ex_instr;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         commit_valid_q <= 1'b0;
         commit_pc_q    <= 64'd0;
         commit_instr_q <= 32'd0;
      end else begin
         commit_valid_q <= retire;
         if (retire) begin
            commit_pc_q    <= (state_q == S_LOAD_WAIT) ? ld_pc_q    : bus.ex_pc;
            commit_instr_q <= (state_q == S_LOAD_WAIT) ? ld_instr_q : bus.ex_instr;
         end
      end
   end

   assign bus.commit_valid = commit_valid_q;
   assign bus.commit_pc    = commit_pc_q;
   assign bus.commit_instr = commit_instr_q;
`else
   logic unused_trace;
   assign unused_trace     = ^{bus.ex_pc, bus.ex_instr};
   assign bus.commit_valid = 1'b0;
   assign bus.commit_pc    = 64'd0;
   assign bus.commit_instr = 32'd0;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed test-plan cases with literal expectations, then
// random traffic checked every cycle against a transaction-level model.
module tb_wb_stage;
   localparam int TMO = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   wb_stage_if #(.INSTRET_W(64)) bus ();

   wb_stage #(.LOAD_TIMEOUT(TMO), .INSTRET_W(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Model: a pending-load record plus the expected registered outputs.
   bit          m_busy;
   int          m_wait;
   logic [4:0]  m_rd;
   logic [2:0]  m_f3, m_off;
   logic [63:0] m_pc;
   logic [31:0] m_instr;
   logic        e_wr_en, e_err, e_cv;
   logic [4:0]  e_wr_addr;
   logic [63:0] e_wr_data, e_instret, e_cpc;
   logic [31:0] e_cinstr;

   // Byte-wise load value: gather the addressed bytes, then extend from the top one.
   function automatic logic [63:0] load_value(input logic [63:0] d, input logic [2:0] off,
                                              input logic [2:0] f3);
      int n;
      int o;
      logic [63:0] v;
      logic [7:0]  b;
      case (f3[1:0])
         2'd0:    n = 1;
         2'd1:    n = 2;
         2'd2:    n = 4;
         default: n = 8;
      endcase
      o = int'(off);
      v = 64'd0;
      for (int i = 0; i < n; i++) begin
         b = (o + i < 8) ? d[(o + i) * 8 +: 8] : 8'h00;
         v = v | (64'(b) << (8 * i));
      end
      if (!f3[2] && n < 8 && v[8 * n - 1]) v = v | (~64'd0 << (8 * n));
      return v;
   endfunction

   task automatic model_reset();
      m_busy    = 0;
      m_wait    = 0;
      e_wr_en   = 0;
      e_err     = 0;
      e_cv      = 0;
      e_wr_addr = 0;
      e_wr_data = 0;
      e_instret = 0;
      e_cpc     = 0;
      e_cinstr  = 0;
   endtask

   task automatic model_retire(input logic [4:0] rd, input logic [63:0] val,
                               input logic [63:0] pc, input logic [31:0] instr);
      e_instret = e_instret + 1;
      e_cv      = 1;
      e_cpc     = pc;
      e_cinstr  = instr;
      if (rd != 0) begin
         e_wr_en   = 1;
         e_wr_addr = rd;
         e_wr_data = val;
      end
   endtask

   task automatic model_step();
      e_wr_en = 0;
      e_err   = 0;
      e_cv    = 0;
      if (!m_busy) begin
         if (bus.ex_valid) begin
            if (bus.ex_is_load) begin
               m_busy  = 1;
               m_wait  = 0;
               m_rd    = bus.ex_rd;
               m_f3    = bus.ex_funct3;
               m_off   = bus.ex_result[2:0];
               m_pc    = bus.ex_pc;
               m_instr = bus.ex_instr;
            end else begin
               model_retire(bus.ex_rd, bus.ex_result, bus.ex_pc, bus.ex_instr);
            end
         end
      end else if (bus.mem_rvalid) begin
         model_retire(m_rd, load_value(bus.mem_rdata, m_off, m_f3), m_pc, m_instr);
         m_busy = 0;
      end else begin
         m_wait++;
         if (m_wait == TMO) begin
            e_err  = 1;
            m_busy = 0;
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst) model_reset();
      check("wr_en",    bus.wr_en,    e_wr_en);
      check("wr_addr",  bus.wr_addr,  e_wr_addr);
      check("wr_data",  bus.wr_data,  e_wr_data);
      check("load_err", bus.load_err, e_err);
      check("instret",  bus.instret,  e_instret);
      check("ex_ready", bus.ex_ready, !m_busy);
      check("mem_req",  bus.mem_req,  bus.ex_valid & !m_busy & bus.ex_is_load);
      check("mem_addr", bus.mem_addr, bus.ex_result);
`ifdef WB_COMMIT_TRACE_EN
      check("commit_valid", bus.commit_valid, e_cv);
      if (e_cv) begin
         check("commit_pc",    bus.commit_pc,    e_cpc);
         check("commit_instr", bus.commit_instr, e_cinstr);
      end
`else
      check("commit_valid", bus.commit_valid, 1'b0);
      check("commit_pc",    bus.commit_pc,    64'd0);
      check("commit_instr", bus.commit_instr, 64'd0);
`endif
      if (rst) model_step();
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_ex(input logic ld, input logic [4:0] rd, input logic [63:0] res,
                           input logic [2:0] f3, input logic [63:0] pc, input logic [31:0] instr);
      bus.ex_valid   = 1'b1;
      bus.ex_is_load = ld;
      bus.ex_rd      = rd;
      bus.ex_result  = res;
      bus.ex_funct3  = f3;
      bus.ex_pc      = pc;
      bus.ex_instr   = instr;
   endtask

   initial begin
      bus.ex_valid   = 0;
      bus.ex_is_load = 0;
      bus.ex_rd      = 0;
      bus.ex_result  = 0;
      bus.ex_funct3  = 0;
      bus.ex_pc      = 0;
      bus.ex_instr   = 0;
      bus.mem_rvalid = 0;
      bus.mem_rdata  = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      @(negedge clk);
      check("rst wr_en", bus.wr_en, 0);
      check("rst instret", bus.instret, 0);
      check("rst ex_ready", bus.ex_ready, 1);
      step();

      // ALU result to x5, with trace fields
      drive_ex(0, 5'd5, 64'h1234, 3'b000, 64'h8000_0000, 32'h0000_0013);
      step();
      bus.ex_valid = 0;
      @(negedge clk);
      check("alu wr_en", bus.wr_en, 1);
      check("alu wr_addr", bus.wr_addr, 5);
      check("alu wr_data", bus.wr_data, 64'h1234);
      check("alu instret", bus.instret, 1);
`ifdef WB_COMMIT_TRACE_EN
      check("trace valid", bus.commit_valid, 1);
      check("trace pc", bus.commit_pc, 64'h8000_0000);
      check("trace instr", bus.commit_instr, 64'h13);
`else
      check("trace off", bus.commit_valid, 0);
`endif
      step();

      // LB then LBU at offset 3, data returned two cycles after accept
      for (int k = 0; k < 2; k++) begin
         drive_ex(1, 5'd7 + 5'(k), 64'h1003, (k == 0) ? 3'b000 : 3'b100, 64'h100, 32'h3);
         @(negedge clk);
         check("load mem_req", bus.mem_req, 1);
         step();
         bus.ex_valid = 0;
         @(negedge clk);
         check("load wait ex_ready", bus.ex_ready, 0);
         step();
         bus.mem_rvalid = 1;
         bus.mem_rdata  = 64'h0000_0000_8000_0000;
         step();
         bus.mem_rvalid = 0;
         @(negedge clk);
         check("load wr_en", bus.wr_en, 1);
         check("load wr_data", bus.wr_data, (k == 0) ? 64'hFFFF_FFFF_FFFF_FF80 : 64'h80);
         check("load instret", bus.instret, 64'(2 + k));
         step();
      end

      // Back-to-back ALU to x1, x2, x0
      drive_ex(0, 5'd1, 64'h11, 0, 0, 0);
      step();
      drive_ex(0, 5'd2, 64'h22, 0, 0, 0);
      @(negedge clk);
      check("b2b x1 addr", bus.wr_addr, 1);
      check("b2b x1 data", bus.wr_data, 64'h11);
      step();
      drive_ex(0, 5'd0, 64'h33, 0, 0, 0);
      @(negedge clk);
      check("b2b x2 wr_en", bus.wr_en, 1);
      check("b2b x2 addr", bus.wr_addr, 2);
      step();
      bus.ex_valid = 0;
      @(negedge clk);
      check("b2b x0 wr_en", bus.wr_en, 0);
      check("b2b x0 hold data", bus.wr_data, 64'h22);
      check("b2b instret", bus.instret, 6);
      step();

      // Load with no return: abandoned after TMO cycles in LOAD_WAIT
      drive_ex(1, 5'd9, 64'h2000, 3'b011, 0, 0);
      step();
      bus.ex_valid = 0;
      repeat (3) step();
      @(negedge clk);
      check("tmo pre load_err", bus.load_err, 0);
      check("tmo pre ex_ready", bus.ex_ready, 0);
      step();
      @(negedge clk);
      check("tmo load_err", bus.load_err, 1);
      check("tmo wr_en", bus.wr_en, 0);
      check("tmo ex_ready", bus.ex_ready, 1);
      check("tmo instret", bus.instret, 6);
      step();
      @(negedge clk);
      check("tmo load_err pulse", bus.load_err, 0);
      step();

      // Reset while a load is pending, stray return after release
      drive_ex(1, 5'd10, 64'h3000, 3'b011, 0, 0);
      step();
      bus.ex_valid = 0;
      rst = 1'b0;
      @(negedge clk);
      check("mid-rst wr_addr", bus.wr_addr, 0);
      check("mid-rst instret", bus.instret, 0);
      check("mid-rst ex_ready", bus.ex_ready, 1);
      step();
      rst = 1'b1;
      bus.mem_rvalid = 1;
      bus.mem_rdata  = {$urandom, $urandom};
      step();
      bus.mem_rvalid = 0;
      @(negedge clk);
      check("post-rst wr_en", bus.wr_en, 0);
      check("post-rst wr_data", bus.wr_data, 0);
      check("post-rst instret", bus.instret, 0);
      step();

      // Random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         bus.ex_valid   = ($urandom_range(3) != 0);
         bus.ex_is_load = $urandom_range(1);
         bus.ex_rd      = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
         bus.ex_result  = {$urandom, $urandom};
         bus.ex_funct3  = 3'($urandom);
         bus.ex_pc      = {$urandom, $urandom};
         bus.ex_instr   = $urandom;
         bus.mem_rvalid = ($urandom_range(2) == 0);
         bus.mem_rdata  = {$urandom, $urandom};
         step();
      end
      bus.ex_valid   = 0;
      bus.mem_rvalid = 0;
      repeat (8) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
